// File: rtl/msrv32_ahb_pkg.sv
// Shared AHB-lite encodings and the data-memory responder state type.
// Also holds the byte-lane merge used for write-to-read forwarding.
package msrv32_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_state_t;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/msrv32_dmem_ram.sv
// Byte-enabled 32-bit word RAM: one write port, one registered read port.
// A same-address read returns the pre-write word; the parent merges in new lanes.
module msrv32_dmem_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [3:0]            i_wr_be,
  input  logic [31:0]           i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [31:0]           o_rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_rd_byte;

      always_ff @(posedge i_clk) begin
        if (i_wr_en && i_wr_be[gi]) r_mem[i_wr_addr] <= i_wr_data[8*gi +: 8];
      end

      // Output register holds its word until the next read is enabled.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_rd_byte <= '0;
        else if (i_rd_en) r_rd_byte <= r_mem[i_rd_addr];
      end

      assign o_rd_data[8*gi +: 8] = r_rd_byte;
    end
  endgenerate

endmodule

// File: rtl/msrv32_dmem_ahb_slave.sv
// AHB-lite data-memory responder: byte-masked writes, registered reads,
// configurable wait states and a two-cycle ERROR for out-of-range addresses.
module msrv32_dmem_ahb_slave
  import msrv32_ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [1:0]  ahb_htrans_in,
  output logic        ahb_ready_out,
  output logic        ahb_hresp_out,
  output logic [31:0] ms_riscv32_mp_dmrd_data_out
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  ahb_state_t            r_state, w_state_next;
  logic [3:0]            r_wait_cnt, w_wait_cnt_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_mask;
  logic                  r_wr;
  logic                  r_oor;
  logic                  r_fwd;
  logic [3:0]            r_fwd_mask;
  logic [31:0]           r_fwd_data;

  logic                  w_accept;
  logic                  w_oor_in;
  logic [ADDR_WIDTH-1:0] w_addr_in;
  logic                  w_commit;
  logic                  w_rd_en;
  logic                  w_fwd_hit;
  logic [31:0]           w_ram_q;
  logic                  w_unused;

  assign w_unused  = ^{ms_riscv32_mp_dmaddr_in[1:0], ahb_htrans_in[0]};
  assign w_oor_in  = |ms_riscv32_mp_dmaddr_in[31:ADDR_WIDTH+2];
  assign w_addr_in = ms_riscv32_mp_dmaddr_in[ADDR_WIDTH+1:2];
  assign w_accept  = ahb_ready_out && ahb_htrans_in[1];
  assign w_commit  = (r_state == ST_DATA) && r_wr && !r_oor;
  assign w_rd_en   = w_accept && !ms_riscv32_mp_dmwr_req_in && !w_oor_in;
  assign w_fwd_hit = w_commit && w_rd_en && (r_addr == w_addr_in);

  assign ahb_ready_out = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign ahb_hresp_out = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_mask     <= '0;
      r_wr       <= 1'b0;
      r_oor      <= 1'b0;
      r_fwd      <= 1'b0;
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_accept) begin
        r_addr <= w_addr_in;
        r_mask <= ms_riscv32_mp_dmwr_mask_in;
        r_wr   <= ms_riscv32_mp_dmwr_req_in;
        r_oor  <= w_oor_in;
      end
      // Forwarding info is tied to the read word and held with it.
      if (w_rd_en) begin
        r_fwd      <= w_fwd_hit;
        r_fwd_mask <= r_mask;
        r_fwd_data <= ms_riscv32_mp_dmdata_in;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      ST_WAIT: begin
        if (r_wait_cnt == 4'd0) w_state_next = ST_DATA;
        else                    w_wait_cnt_next = r_wait_cnt - 4'd1;
      end
      ST_ERR1: w_state_next = ST_ERR2;
      default: begin
        w_state_next = ST_IDLE;
        if (w_accept) begin
          if (w_oor_in) begin
            w_state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_next    = ST_WAIT;
            w_wait_cnt_next = WAIT_LOAD;
          end else begin
            w_state_next = ST_DATA;
          end
        end
      end
    endcase
  end

  msrv32_dmem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_clk    (ms_riscv32_mp_clk_in),
    .i_rst_n  (ms_riscv32_mp_rst_in),
    .i_wr_en  (w_commit),
    .i_wr_addr(r_addr),
    .i_wr_be  (r_mask),
    .i_wr_data(ms_riscv32_mp_dmdata_in),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(w_addr_in),
    .o_rd_data(w_ram_q)
  );

  assign ms_riscv32_mp_dmrd_data_out = r_fwd ? merge_lanes(w_ram_q, r_fwd_data, r_fwd_mask) : w_ram_q;

endmodule
